// File: rtl/inst_fetch_buffer_if.sv
// Bundle between the fetch stage, the instruction buffer and the two decoders.
// Handshake: a fetch group transfers on a rising edge where fetch_vld && fetch_ready && !flush_stage2; slot k is consumed on an edge where instruction_vld_k && !hold_stage3.
interface inst_fetch_buffer_if;
    logic         flush_stage2;
    logic         hold_stage3;
    logic         fetch_vld;
    logic         fetch_ready;
    logic [31:0]  fetch_PC;
    logic [3:0]   fetch_mask;
    logic [127:0] fetch_insts;
    logic [1:0]   fetch_except;
    logic [31:0]  fetch_target;
    logic         instruction_vld_0;
    logic         instruction_vld_1;
    logic [31:0]  instruction_0;
    logic [31:0]  instruction_1;
    logic [31:0]  PC_stage2_0;
    logic [31:0]  PC_stage2_1;
    logic [1:0]   except_stage2_0;
    logic [1:0]   except_stage2_1;
    logic [31:0]  instruction_target_stage2_0;
    logic [31:0]  instruction_target_stage2_1;

    modport slave (
        input  flush_stage2, hold_stage3, fetch_vld, fetch_PC, fetch_mask, fetch_insts,
               fetch_except, fetch_target,
        output fetch_ready, instruction_vld_0, instruction_vld_1, instruction_0, instruction_1,
               PC_stage2_0, PC_stage2_1, except_stage2_0, except_stage2_1,
               instruction_target_stage2_0, instruction_target_stage2_1
    );

    modport master (
        output flush_stage2, hold_stage3, fetch_vld, fetch_PC, fetch_mask, fetch_insts,
               fetch_except, fetch_target,
        input  fetch_ready, instruction_vld_0, instruction_vld_1, instruction_0, instruction_1,
               PC_stage2_0, PC_stage2_1, except_stage2_0, except_stage2_1,
               instruction_target_stage2_0, instruction_target_stage2_1
    );
endinterface

// File: rtl/inst_fetch_buffer.sv
// Instruction buffer: compacts valid lanes of a 4-wide fetch group into an in-order circular
// FIFO and presents the two oldest entries to the decoders.
module inst_fetch_buffer #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    inst_fetch_buffer_if.slave   bus,
    output logic [CNT_W-1:0]     count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - 4);

    logic [31:0]      mem_inst [DEPTH];
    logic [31:0]      mem_pc   [DEPTH];
    logic [31:0]      mem_tgt  [DEPTH];
    logic [1:0]       mem_exc  [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] head_1;

    logic        enq_fire;
    logic [2:0]  enq_num;
    logic [2:0]  enq_eff;
    logic [1:0]  deq_num;
    logic [1:0]  lane_off [4];
    logic [31:0] lane_pc  [4];
    logic [31:0] lane_tgt [4];

    // Lane offset is the popcount of lower valid lanes; the highest valid lane carries fetch_target.
    always_comb begin
        enq_num = '0;
        for (int i = 0; i < 4; i++) begin
            lane_off[i] = enq_num[1:0];
            enq_num     = enq_num + 3'(bus.fetch_mask[i]);
            lane_pc[i]  = {bus.fetch_PC[31:4], 2'(i), 2'b00};
            lane_tgt[i] = ((bus.fetch_mask >> (i + 1)) == 4'd0) ? bus.fetch_target
                                                                 : lane_pc[i] + 32'd4;
        end
        enq_fire = bus.fetch_vld && bus.fetch_ready && !bus.flush_stage2;
        enq_eff  = enq_fire ? enq_num : 3'd0;
        deq_num  = 2'd0;
        if (!bus.hold_stage3) begin
            if (count >= CNT_W'(2)) deq_num = 2'd2;
            else                    deq_num = count[1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (bus.flush_stage2) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(deq_num);
            tail  <= tail + PTR_W'(enq_eff);
            count <= count + CNT_W'(enq_eff) - CNT_W'(deq_num);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < DEPTH; e++) begin
                mem_inst[e] <= '0;
                mem_pc[e]   <= '0;
                mem_tgt[e]  <= '0;
                mem_exc[e]  <= '0;
            end
        end else if (enq_fire) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.fetch_mask[i]) begin
                    mem_inst[tail + PTR_W'(lane_off[i])] <= bus.fetch_insts[32*i +: 32];
                    mem_pc[tail + PTR_W'(lane_off[i])]   <= lane_pc[i];
                    mem_tgt[tail + PTR_W'(lane_off[i])]  <= lane_tgt[i];
                    mem_exc[tail + PTR_W'(lane_off[i])]  <= bus.fetch_except;
                end
            end
        end
    end

    // Ready looks only at the registered count, so a same-cycle dequeue does not open space.
    assign bus.fetch_ready = (count <= READY_MAX);
    assign head_1          = head + PTR_W'(1);

    assign bus.instruction_vld_0           = (count != '0) && !bus.flush_stage2;
    assign bus.instruction_vld_1           = (count >= CNT_W'(2)) && !bus.flush_stage2;
    assign bus.instruction_0               = mem_inst[head];
    assign bus.instruction_1               = mem_inst[head_1];
    assign bus.PC_stage2_0                 = mem_pc[head];
    assign bus.PC_stage2_1                 = mem_pc[head_1];
    assign bus.except_stage2_0             = mem_exc[head];
    assign bus.except_stage2_1             = mem_exc[head_1];
    assign bus.instruction_target_stage2_0 = mem_tgt[head];
    assign bus.instruction_target_stage2_1 = mem_tgt[head_1];
endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Directed bench for inst_fetch_buffer: drivers push expected entries, a negedge monitor pops them
// as the decoder slots are consumed.
module tb_inst_fetch_buffer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] count;
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [97:0] exp_q[$];

    always #5 clk = ~clk;

    inst_fetch_buffer_if bus();

    inst_fetch_buffer #(.DEPTH(16), .CNT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .count (count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic exp_push(input logic [31:0] inst, input logic [31:0] pc,
                            input logic [1:0] exc, input logic [31:0] tgt);
        exp_q.push_back({inst, pc, exc, tgt});
    endtask

    task automatic slot_check(input int slot, input logic [97:0] got);
        logic [97:0] e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL slot%0d_unexpected: got inst=0x%0h pc=0x%0h expected no output",
                     slot, got[97:66], got[65:34]);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                n_fail++;
                $display("FAIL slot%0d_data: got inst=0x%0h pc=0x%0h exc=%0d tgt=0x%0h expected inst=0x%0h pc=0x%0h exc=%0d tgt=0x%0h",
                         slot, got[97:66], got[65:34], got[33:32], got[31:0],
                         e[97:66], e[65:34], e[33:32], e[31:0]);
            end
        end
    endtask

    // Monitor: a valid slot seen with hold low is consumed at the next rising edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && !bus.hold_stage3) begin
            if (bus.instruction_vld_0)
                slot_check(0, {bus.instruction_0, bus.PC_stage2_0, bus.except_stage2_0,
                               bus.instruction_target_stage2_0});
            if (bus.instruction_vld_1)
                slot_check(1, {bus.instruction_1, bus.PC_stage2_1, bus.except_stage2_1,
                               bus.instruction_target_stage2_1});
        end
    end

    task automatic send(input logic [31:0] pc, input logic [3:0] mask, input logic [127:0] insts,
                        input logic [1:0] exc, input logic [31:0] tgt);
        bus.fetch_vld    = 1'b1;
        bus.fetch_PC     = pc;
        bus.fetch_mask   = mask;
        bus.fetch_insts  = insts;
        bus.fetch_except = exc;
        bus.fetch_target = tgt;
        @(posedge clk);
        #1;
        bus.fetch_vld  = 1'b0;
        bus.fetch_mask = 4'd0;
    endtask

    task automatic send_full(input logic [31:0] pc, input logic [31:0] inst_base,
                             input logic [31:0] tgt, input bit expect_stored);
        logic [127:0] insts;
        for (int l = 0; l < 4; l++) begin
            insts[32*l +: 32] = inst_base + 32'(l);
            if (expect_stored)
                exp_push(inst_base + 32'(l), pc + 32'(4*l), 2'd0,
                         (l == 3) ? tgt : pc + 32'(4*l + 4));
        end
        send(pc, 4'b1111, insts, 2'd0, tgt);
    endtask

    task automatic wait_drain();
        int cyc = 0;
        @(negedge clk);
        while (count != 5'd0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("drain_count", 32'(count), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n            = 1'b0;
        bus.flush_stage2 = 1'b0;
        bus.hold_stage3  = 1'b0;
        bus.fetch_vld    = 1'b0;
        bus.fetch_PC     = '0;
        bus.fetch_mask   = '0;
        bus.fetch_insts  = '0;
        bus.fetch_except = '0;
        bus.fetch_target = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_vld_0", 32'(bus.instruction_vld_0), 32'd0);
        check("rst_ready", 32'(bus.fetch_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_vld_1", 32'(bus.instruction_vld_1), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_inst_0", bus.instruction_0, 32'd0);
        check("rst_pc_1", bus.PC_stage2_1, 32'd0);

        // Full group A..D
        exp_push(32'hA000_0001, 32'h1C00_0000, 2'd0, 32'h1C00_0004);
        exp_push(32'hB000_0002, 32'h1C00_0004, 2'd0, 32'h1C00_0008);
        exp_push(32'hC000_0003, 32'h1C00_0008, 2'd0, 32'h1C00_000C);
        exp_push(32'hD000_0004, 32'h1C00_000C, 2'd0, 32'h1C00_0040);
        send(32'h1C00_0000, 4'b1111,
             {32'hD000_0004, 32'hC000_0003, 32'hB000_0002, 32'hA000_0001}, 2'd0, 32'h1C00_0040);
        @(negedge clk);
        check("full_count4", 32'(count), 32'd4);
        check("full_vld_1", 32'(bus.instruction_vld_1), 32'd1);
        @(negedge clk);
        check("full_count2", 32'(count), 32'd2);
        @(negedge clk);
        check("full_count0", 32'(count), 32'd0);
        check("full_vld_0_off", 32'(bus.instruction_vld_0), 32'd0);

        // Sparse mask 0110 with exception code
        exp_push(32'h1111_1111, 32'h1C00_0014, 2'd2, 32'h1C00_0018);
        exp_push(32'h2222_2222, 32'h1C00_0018, 2'd2, 32'h1C00_0100);
        send(32'h1C00_0010, 4'b0110,
             {32'hDEAD_0003, 32'h2222_2222, 32'h1111_1111, 32'hDEAD_0000}, 2'd2, 32'h1C00_0100);
        @(negedge clk);
        check("sparse_count", 32'(count), 32'd2);
        check("sparse_exc_0", 32'(bus.except_stage2_0), 32'd2);
        check("sparse_exc_1", 32'(bus.except_stage2_1), 32'd2);
        @(negedge clk);
        check("sparse_drained", 32'(count), 32'd0);

        // Empty mask writes nothing
        send(32'h1C00_0020, 4'b0000, {4{32'hBAD0_BAD0}}, 2'd0, 32'h1C00_0030);
        @(negedge clk);
        check("mask0_count", 32'(count), 32'd0);
        check("mask0_vld_0", 32'(bus.instruction_vld_0), 32'd0);

        // Fill under hold, fifth group dropped, then drain two per cycle
        @(posedge clk);
        #1;
        bus.hold_stage3 = 1'b1;
        for (int g = 0; g < 4; g++) begin
            send_full(32'h1C00_1000 + 32'(16*g), 32'hF000_0000 + 32'(4*g), 32'h2000_0000 + 32'(g), 1'b1);
            if (g == 2) begin
                @(negedge clk);
                check("fill_count12", 32'(count), 32'd12);
                check("fill_ready12", 32'(bus.fetch_ready), 32'd1);
            end
        end
        @(negedge clk);
        check("fill_count16", 32'(count), 32'd16);
        check("fill_ready16", 32'(bus.fetch_ready), 32'd0);
        send_full(32'h1C00_9000, 32'hEEEE_0000, 32'h1C00_9100, 1'b0);
        @(negedge clk);
        check("drop_count16", 32'(count), 32'd16);
        @(posedge clk);
        #1;
        bus.hold_stage3 = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("release_count", 32'(count), 32'(16 - 2*k));
            check("release_ready", 32'(bus.fetch_ready), (16 - 2*k <= 12) ? 32'd1 : 32'd0);
        end
        check("release_vld_0", 32'(bus.instruction_vld_0), 32'd0);

        // Advance pointers from 6 to 14, then wrap a group across 15->0
        send_full(32'h1C00_2000, 32'h5000_0000, 32'h1C00_2050, 1'b1);
        send_full(32'h1C00_2010, 32'h5000_0010, 32'h1C00_2060, 1'b1);
        wait_drain();
        send_full(32'h1C00_3000, 32'h7000_0000, 32'h1C00_3100, 1'b1);
        exp_push(32'h7777_0001, 32'h1C00_3010, 2'd0, 32'h1C00_3200);
        send(32'h1C00_3010, 4'b0001, {96'd0, 32'h7777_0001}, 2'd0, 32'h1C00_3200);
        @(negedge clk);
        check("wrap_count3", 32'(count), 32'd3);
        @(negedge clk);
        check("wrap_count1", 32'(count), 32'd1);
        check("wrap_vld_0", 32'(bus.instruction_vld_0), 32'd1);
        check("wrap_vld_1", 32'(bus.instruction_vld_1), 32'd0);
        wait_drain();

        // Flush with count=5, hold and an incoming group
        @(posedge clk);
        #1;
        bus.hold_stage3 = 1'b1;
        send_full(32'h1C00_4000, 32'h4000_0000, 32'h1C00_4100, 1'b0);
        send(32'h1C00_4010, 4'b0001, {96'd0, 32'h4444_0004}, 2'd0, 32'h1C00_4200);
        bus.flush_stage2 = 1'b1;
        bus.fetch_vld    = 1'b1;
        bus.fetch_PC     = 32'h1C00_5000;
        bus.fetch_mask   = 4'b1111;
        bus.fetch_insts  = {4{32'h5555_5555}};
        @(negedge clk);
        check("flush_count5", 32'(count), 32'd5);
        check("flush_vld_0", 32'(bus.instruction_vld_0), 32'd0);
        check("flush_vld_1", 32'(bus.instruction_vld_1), 32'd0);
        @(posedge clk);
        #1;
        bus.flush_stage2 = 1'b0;
        bus.fetch_vld    = 1'b0;
        bus.fetch_mask   = 4'd0;
        bus.hold_stage3  = 1'b0;
        @(negedge clk);
        check("post_flush_count", 32'(count), 32'd0);
        check("post_flush_ready", 32'(bus.fetch_ready), 32'd1);
        check("post_flush_vld_0", 32'(bus.instruction_vld_0), 32'd0);
        exp_push(32'h6000_0000, 32'h1C00_6000, 2'd1, 32'h1C00_6004);
        exp_push(32'h6000_0001, 32'h1C00_6004, 2'd1, 32'h1C00_6300);
        send(32'h1C00_6000, 4'b0011, {64'd0, 32'h6000_0001, 32'h6000_0000}, 2'd1, 32'h1C00_6300);
        @(negedge clk);
        check("post_flush_pc_0", bus.PC_stage2_0, 32'h1C00_6000);
        wait_drain();

        // Asynchronous reset mid-operation
        @(posedge clk);
        #1;
        bus.hold_stage3 = 1'b1;
        send_full(32'h1C00_7000, 32'h8000_0000, 32'h1C00_7100, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_vld_0", 32'(bus.instruction_vld_0), 32'd0);
        check("midrst_ready", 32'(bus.fetch_ready), 32'd1);
        check("midrst_inst_0", bus.instruction_0, 32'd0);
        bus.hold_stage3 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
